// File: rtl/axi_wr_slave_ep.sv
// AXI write-slave endpoint: queues AW requests, walks INCR bursts onto a memory write port, returns one B per burst.
// Optional build macro AXI_WR_STRB_CHK_EN: an all-zero wstrb beat is flagged as an error and not written.
module axi_wr_slave_ep #(
  parameter int PID_WIDTH     = 4,
  parameter int PADDR_WIDTH   = 32,
  parameter int PLENGTH_WIDTH = 8,
  parameter int PSIZE_WIDTH   = 3,
  parameter int PDATA_WIDTH   = 4,
  parameter int AW_DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [PID_WIDTH-1:0]     awid,
  input  logic [PADDR_WIDTH-1:0]   awaddr,
  input  logic [PLENGTH_WIDTH-1:0] awlen,
  input  logic [PSIZE_WIDTH-1:0]   awsize,
  input  logic [1:0]               awburst,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [PID_WIDTH-1:0]     wid,
  input  logic [PDATA_WIDTH*8-1:0] wdata,
  input  logic [PDATA_WIDTH-1:0]   wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [PID_WIDTH-1:0]     bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  output logic                     mem_we,
  output logic [PADDR_WIDTH-1:0]   mem_addr,
  output logic [PDATA_WIDTH*8-1:0] mem_wdata,
  output logic [PDATA_WIDTH-1:0]   mem_wstrb
);

  localparam int PTR_W = $clog2(AW_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [PID_WIDTH-1:0]     id;
    logic [PADDR_WIDTH-1:0]   addr;
    logic [PLENGTH_WIDTH-1:0] len;
    logic [PSIZE_WIDTH-1:0]   size;
    logic [1:0]               burst;
  } aw_entry_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_BURST = 2'b01,
    S_RESP  = 2'b10
  } state_t;

  aw_entry_t                fifo_r [AW_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [CNT_W-1:0]         count_nxt_s;
  logic                     awready_r;
  aw_entry_t                head_s;
  logic                     push_s;
  logic                     pop_s;
  logic                     load_s;
  logic                     beat_s;
  logic                     we_s;
  logic                     strb_err_s;
  logic                     beat_err_s;
  state_t                   state_r;
  state_t                   state_nxt_s;
  logic                     wready_r;
  logic [PADDR_WIDTH-1:0]   cur_addr_r;
  logic [PLENGTH_WIDTH-1:0] beat_cnt_r;
  logic                     err_r;
  logic                     bvalid_r;
  logic [PID_WIDTH-1:0]     bid_r;
  logic [1:0]               bresp_r;
  logic                     mem_we_r;
  logic [PADDR_WIDTH-1:0]   mem_addr_r;
  logic [PDATA_WIDTH*8-1:0] mem_wdata_r;
  logic [PDATA_WIDTH-1:0]   mem_wstrb_r;

  assign head_s      = fifo_r[rd_ptr_r];
  assign push_s      = awvalid && awready_r;
  assign count_nxt_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

`ifdef AXI_WR_STRB_CHK_EN
  assign strb_err_s = (wstrb == {PDATA_WIDTH{1'b0}});
`else
  assign strb_err_s = 1'b0;
`endif

  // A beat past len without wlast is caught at the beat that should have carried wlast; err is sticky.
  assign beat_err_s = (wid != head_s.id) ||
                      (wlast && (beat_cnt_r != head_s.len)) ||
                      (!wlast && (beat_cnt_r == head_s.len)) ||
                      (head_s.burst != 2'b01) ||
                      strb_err_s;
  assign we_s = beat_s && !strb_err_s;

  // AW queue storage; contents need no reset since count_r qualifies them.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= '{id: awid, addr: awaddr, len: awlen, size: awsize, burst: awburst};
    end
  end

  // AW queue pointers, occupancy and the registered not-full ready.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_r  <= {PTR_W{1'b0}};
      rd_ptr_r  <= {PTR_W{1'b0}};
      count_r   <= {CNT_W{1'b0}};
      awready_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
      end
      count_r   <= count_nxt_s;
      awready_r <= (count_nxt_s != CNT_W'(AW_DEPTH));
    end
  end

  // Burst sequencing: next state, head load, beat acceptance and head pop.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    pop_s       = 1'b0;
    beat_s      = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          state_nxt_s = S_BURST;
          load_s      = 1'b1;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_BURST: begin
        beat_s = wvalid && wready_r;
        if (beat_s && wlast) begin
          state_nxt_s = S_RESP;
          pop_s       = 1'b1;
        end else begin
          state_nxt_s = S_BURST;
        end
      end
      S_RESP: begin
        if (bvalid_r && bready) begin
          if (count_r != {CNT_W{1'b0}}) begin
            state_nxt_s = S_BURST;
            load_s      = 1'b1;
          end else begin
            state_nxt_s = S_IDLE;
          end
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, beat datapath, memory port and B channel registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= S_IDLE;
      wready_r    <= 1'b0;
      cur_addr_r  <= {PADDR_WIDTH{1'b0}};
      beat_cnt_r  <= {PLENGTH_WIDTH{1'b0}};
      err_r       <= 1'b0;
      bvalid_r    <= 1'b0;
      bid_r       <= {PID_WIDTH{1'b0}};
      bresp_r     <= 2'b00;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {PADDR_WIDTH{1'b0}};
      mem_wdata_r <= {(PDATA_WIDTH*8){1'b0}};
      mem_wstrb_r <= {PDATA_WIDTH{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      wready_r <= (state_nxt_s == S_BURST);
      mem_we_r <= we_s;
      if (load_s) begin
        cur_addr_r <= head_s.addr;
        beat_cnt_r <= {PLENGTH_WIDTH{1'b0}};
        err_r      <= 1'b0;
      end
      if (beat_s) begin
        mem_addr_r  <= cur_addr_r;
        mem_wdata_r <= wdata;
        mem_wstrb_r <= wstrb;
        cur_addr_r  <= cur_addr_r + (PADDR_WIDTH'(1'b1) << head_s.size);
        if (beat_cnt_r != {PLENGTH_WIDTH{1'b1}}) begin
          beat_cnt_r <= beat_cnt_r + PLENGTH_WIDTH'(1'b1);
        end
        err_r <= err_r | beat_err_s;
      end
      if (beat_s && wlast) begin
        bvalid_r <= 1'b1;
        bid_r    <= head_s.id;
        bresp_r  <= (err_r || beat_err_s) ? 2'b10 : 2'b00;
      end else if (bvalid_r && bready) begin
        bvalid_r <= 1'b0;
      end
    end
  end

  assign awready   = awready_r;
  assign wready    = wready_r;
  assign bvalid    = bvalid_r;
  assign bid       = bid_r;
  assign bresp     = bresp_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wstrb = mem_wstrb_r;

endmodule

// File: tb/tb_axi_wr_slave_ep.sv
// Directed bench for axi_wr_slave_ep; inputs change and outputs are sampled on the falling clock edge.
module tb_axi_wr_slave_ep;

  logic        clk = 1'b0;
  logic        resetn;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int vec_cnt = 0;
  int miscmp_cnt = 0;
  int base;
  logic [31:0] log_addr[$];
  logic [31:0] log_data[$];

  axi_wr_slave_ep dut (
    .clk(clk), .resetn(resetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 clk = ~clk;

  // Records every memory write strobe for later comparison.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_wdata);
    end
  end

  task automatic chk_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_data(input int tag, input int beat);
    return 32'hC0DE_0000 | (32'(tag) << 8) | 32'(beat);
  endfunction

  function automatic logic [31:0] addr_at(input int idx);
    if (idx < log_addr.size()) return log_addr[idx];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] data_at(input int idx);
    if (idx < log_data.size()) return log_data[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk_wr(input string tag, input int idx, input logic [31:0] ea, input logic [31:0] ed);
    chk_vec({tag, "_addr"}, addr_at(base + idx), ea);
    chk_vec({tag, "_data"}, data_at(base + idx), ed);
  endtask

  task automatic chk_reset(input string tag);
    chk_vec({tag, "_awready"}, awready, 1'b0);
    chk_vec({tag, "_wready"}, wready, 1'b0);
    chk_vec({tag, "_bvalid"}, bvalid, 1'b0);
    chk_vec({tag, "_bid"}, bid, 4'h0);
    chk_vec({tag, "_bresp"}, bresp, 2'b00);
    chk_vec({tag, "_mem_we"}, mem_we, 1'b0);
    chk_vec({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk_vec({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk_vec({tag, "_mem_wstrb"}, mem_wstrb, 4'h0);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size);
    int n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = 2'b01; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_vec("aw_handshake", 64'(n < 50), 64'd1);
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  task automatic w_beat(input logic [3:0] id, input logic [31:0] data, input logic [3:0] strb,
                        input logic last);
    int n = 0;
    wid = id; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    while (wready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_vec("w_handshake", 64'(n < 50), 64'd1);
    @(negedge clk);
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic take_b(input string tag, input logic [3:0] eid, input logic [1:0] eresp);
    int n = 0;
    while (bvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk_vec({tag, "_bvalid"}, bvalid, 1'b1);
    chk_vec({tag, "_bid"}, bid, eid);
    chk_vec({tag, "_bresp"}, bresp, eresp);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; bready = 1'b0;
    awid = 4'h0; awaddr = 32'h0; awlen = 8'h0; awsize = 3'h0; awburst = 2'b00; awvalid = 1'b0;
    wid = 4'h0; wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset("rst");
    resetn = 1'b1;
    @(negedge clk);
    chk_vec("rst_awready_up", awready, 1'b1);
    chk_vec("rst_wready_idle", wready, 1'b0);

    // 1: basic 4-beat INCR burst, size 4 bytes
    base = log_addr.size();
    send_aw(4'd3, 32'h100, 8'd3, 3'd2);
    chk_vec("t1_wready_after_aw", wready, 1'b0);
    for (int i = 0; i < 4; i++) w_beat(4'd3, mk_data(1, i), 4'hF, i == 3);
    chk_vec("t1_b_latency", bvalid, 1'b1);
    chk_vec("t1_wready_resp", wready, 1'b0);
    take_b("t1", 4'd3, 2'b00);
    chk_vec("t1_nwr", log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) chk_wr("t1_wr", i, 32'h100 + 32'(4 * i), mk_data(1, i));

    // 2: AW queue fills at 4, frees on the first completed burst
    base = log_addr.size();
    for (int i = 1; i <= 4; i++) send_aw(4'(i), 32'h100 * 32'(i + 1), 8'd0, 3'd2);
    chk_vec("t2_full", awready, 1'b0);
    awid = 4'd5; awaddr = 32'h600; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk_vec("t2_still_full", awready, 1'b0);
    w_beat(4'd1, mk_data(2, 1), 4'hF, 1'b1);
    chk_vec("t2_freed", awready, 1'b1);
    send_aw(4'd5, 32'h600, 8'd0, 3'd2);
    chk_vec("t2_full_again", awready, 1'b0);
    take_b("t2_1", 4'd1, 2'b00);
    for (int i = 2; i <= 5; i++) begin
      w_beat(4'(i), mk_data(2, i), 4'hF, 1'b1);
      take_b("t2_n", 4'(i), 2'b00);
    end
    chk_vec("t2_nwr", log_addr.size() - base, 5);
    for (int i = 0; i < 5; i++) chk_wr("t2_wr", i, 32'h200 + 32'h100 * 32'(i), mk_data(2, i + 1));

    // 3: early wlast, then the queued burst at its own address (8-byte beats)
    base = log_addr.size();
    send_aw(4'd6, 32'h1000, 8'd3, 3'd2);
    send_aw(4'd7, 32'h2000, 8'd1, 3'd3);
    w_beat(4'd6, mk_data(3, 0), 4'hF, 1'b0);
    w_beat(4'd6, mk_data(3, 1), 4'hF, 1'b1);
    take_b("t3a", 4'd6, 2'b10);
    w_beat(4'd7, mk_data(3, 2), 4'hF, 1'b0);
    w_beat(4'd7, mk_data(3, 3), 4'hF, 1'b1);
    take_b("t3b", 4'd7, 2'b00);
    chk_wr("t3_wr0", 0, 32'h1000, mk_data(3, 0));
    chk_wr("t3_wr1", 1, 32'h1004, mk_data(3, 1));
    chk_wr("t3_wr2", 2, 32'h2000, mk_data(3, 2));
    chk_wr("t3_wr3", 3, 32'h2008, mk_data(3, 3));

    // 4: B backpressure for 5 cycles
    send_aw(4'd8, 32'h3000, 8'd0, 3'd2);
    send_aw(4'd9, 32'h3100, 8'd0, 3'd2);
    base = log_addr.size();
    w_beat(4'd8, mk_data(4, 0), 4'hF, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk_vec("t4_hold_bvalid", bvalid, 1'b1);
      chk_vec("t4_hold_bid", bid, 4'd8);
      chk_vec("t4_hold_bresp", bresp, 2'b00);
      chk_vec("t4_hold_wready", wready, 1'b0);
      @(negedge clk);
    end
    take_b("t4a", 4'd8, 2'b00);
    chk_vec("t4_nwr_hold", log_addr.size() - base, 1);
    w_beat(4'd9, mk_data(4, 1), 4'hF, 1'b1);
    take_b("t4b", 4'd9, 2'b00);
    chk_wr("t4_wr0", 0, 32'h3000, mk_data(4, 0));
    chk_wr("t4_wr1", 1, 32'h3100, mk_data(4, 1));

    // 5: wrong wid on beat 2 still writes every beat
    base = log_addr.size();
    send_aw(4'd10, 32'h4000, 8'd3, 3'd2);
    for (int i = 0; i < 4; i++) w_beat((i == 1) ? 4'd5 : 4'd10, mk_data(5, i), 4'hF, i == 3);
    take_b("t5", 4'd10, 2'b10);
    chk_vec("t5_nwr", log_addr.size() - base, 4);
    for (int i = 0; i < 4; i++) chk_wr("t5_wr", i, 32'h4000 + 32'(4 * i), mk_data(5, i));

    // 6: reset in the middle of a burst drops it and the queued one
    send_aw(4'd11, 32'h5000, 8'd3, 3'd2);
    send_aw(4'd12, 32'h5800, 8'd0, 3'd2);
    w_beat(4'd11, mk_data(6, 0), 4'hF, 1'b0);
    w_beat(4'd11, mk_data(6, 1), 4'hF, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    chk_reset("t6_rst");
    resetn = 1'b1;
    base = log_addr.size();
    for (int i = 0; i < 6; i++) begin
      chk_vec("t6_no_b", bvalid, 1'b0);
      chk_vec("t6_no_wready", wready, 1'b0);
      @(negedge clk);
    end
    chk_vec("t6_nwr", log_addr.size() - base, 0);
    send_aw(4'd13, 32'h6000, 8'd1, 3'd2);
    w_beat(4'd13, mk_data(6, 2), 4'hF, 1'b0);
    w_beat(4'd13, mk_data(6, 3), 4'hF, 1'b1);
    take_b("t6b", 4'd13, 2'b00);
    chk_wr("t6_wr0", 0, 32'h6000, mk_data(6, 2));
    chk_wr("t6_wr1", 1, 32'h6004, mk_data(6, 3));

    // 7: all-zero strobe on the middle beat
    base = log_addr.size();
    send_aw(4'd14, 32'h7000, 8'd2, 3'd2);
    w_beat(4'd14, mk_data(7, 0), 4'hF, 1'b0);
    w_beat(4'd14, mk_data(7, 1), 4'h0, 1'b0);
    w_beat(4'd14, mk_data(7, 2), 4'hF, 1'b1);
`ifdef AXI_WR_STRB_CHK_EN
    take_b("t7", 4'd14, 2'b10);
    chk_vec("t7_nwr", log_addr.size() - base, 2);
    chk_wr("t7_wr0", 0, 32'h7000, mk_data(7, 0));
    chk_wr("t7_wr1", 1, 32'h7008, mk_data(7, 2));
`else
    take_b("t7", 4'd14, 2'b00);
    chk_vec("t7_nwr", log_addr.size() - base, 3);
    for (int i = 0; i < 3; i++) chk_wr("t7_wr", i, 32'h7000 + 32'(4 * i), mk_data(7, i));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
